mulalu: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Consumes that ALU's mulalu_func/mulalu_sign outputs and the same operands.
- Computes the 64-bit product or the quotient/remainder and writes the HI/LO registers.
- Asserts busy to stall the pipeline while an operation is in flight.

---
 rtl/mulalu.sv | 153 +++++++++++++++
 tb/tb_mulalu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mulalu.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU; writes HI/LO and
// holds busy while a MUL or DIV is in flight.
//
// state | meaning
// IDLE  | waiting for a MUL/DIV request
// MUL   | product settling, count down to terminal count 0
// DIV   | restoring division, one quotient bit per cycle
// DONE  | result on hi/lo_write_data, write strobe on first cycle only

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'b11000
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b11010
`endif

module mulalu #(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 ex_hold,
   input  logic [`W_FUNC-1:0]   mulalu_func,
   input  logic                 mulalu_sign,
   input  logic [`W_DATA-1:0]   source_a,
   input  logic [`W_DATA-1:0]   source_b,
   output logic                 busy,
   output logic                 hi_write,
   output logic [`W_DATA-1:0]   hi_write_data,
   output logic                 lo_write,
   output logic [`W_DATA-1:0]   lo_write_data
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [2:0]         count;
   logic [4:0]         iteration;
   logic [31:0]        op_a, op_b;
   logic               op_sign;
   logic [31:0]        rem, quot;
   logic [31:0]        hi_res, lo_res;
   logic               done_first;

   logic               is_mul, is_div, start;
   logic [31:0]        src_mag_a, div_mag;
   logic [63:0]        mul_a64, mul_b64, product;
   logic [32:0]        shifted;
   logic               ge;
   logic [31:0]        rem_step, quot_step;
   logic [31:0]        hi_div, lo_div;

   assign is_mul = (mulalu_func == `FUNC_MUL);
   assign is_div = (mulalu_func == `FUNC_DIV);
   assign start  = (state == IDLE) & (is_mul | is_div) & ~flush;

   assign src_mag_a = (mulalu_sign & source_a[31]) ? (~source_a + 32'd1) : source_a;
   assign div_mag   = (op_sign & op_b[31]) ? (~op_b + 32'd1) : op_b;

   // Low 64 bits of a 64x64 product are correct for two's-complement operands.
   assign mul_a64 = {{32{op_sign & op_a[31]}}, op_a};
   assign mul_b64 = {{32{op_sign & op_b[31]}}, op_b};
   assign product = mul_a64 * mul_b64;

   assign shifted   = {rem, quot[31]};
   assign ge        = (shifted >= {1'b0, div_mag});
   assign rem_step  = ge ? 32'(shifted - {1'b0, div_mag}) : shifted[31:0];
   assign quot_step = {quot[30:0], ge};

   always_comb begin
      hi_div = (op_sign & op_a[31]) ? (~rem_step + 32'd1) : rem_step;
      lo_div = (op_sign & (op_a[31] ^ op_b[31])) ? (~quot_step + 32'd1) : quot_step;
      if (op_b == 32'd0) begin
         hi_div = op_a;
         lo_div = 32'hFFFF_FFFF;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (start) state_nxt = is_mul ? MUL : DIV;
            MUL:  if (count == 3'd0) state_nxt = DONE;
            DIV:  if (iteration == 5'(DIV_ITER - 1)) state_nxt = DONE;
            DONE: if (!ex_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         iteration  <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_sign    <= 1'b0;
         rem        <= '0;
         quot       <= '0;
         hi_res     <= '0;
         lo_res     <= '0;
         done_first <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_first <= (state != DONE) & (state_nxt == DONE);
         if (start) begin
            op_a    <= source_a;
            op_b    <= source_b;
            op_sign <= mulalu_sign;
            if (is_mul) begin
               count <= 3'(MUL_LAT - 1);
            end else begin
               iteration <= '0;
               rem       <= '0;
               quot      <= src_mag_a;
            end
         end else if (!flush && state == MUL) begin
            count <= count - 3'd1;
            if (count == 3'd0) begin
               hi_res <= product[63:32];
               lo_res <= product[31:0];
            end
         end else if (!flush && state == DIV) begin
            iteration <= iteration + 5'd1;
            rem       <= rem_step;
            quot      <= quot_step;
            if (iteration == 5'(DIV_ITER - 1)) begin
               hi_res <= hi_div;
               lo_res <= lo_div;
            end
         end
      end
   end

   assign busy          = start | (state == MUL) | (state == DIV);
   assign hi_write      = (state == DONE) & done_first;
   assign lo_write      = (state == DONE) & done_first;
   assign hi_write_data = hi_res;
   assign lo_write_data = lo_res;

endmodule

// File: tb/tb_mulalu.sv
// Directed bench for mulalu: hand-computed MUL/DIV vectors plus flush,
// ex_hold and mid-operation reset cases.

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'b11000
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b11010
`endif

module tb_mulalu;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                flush = 1'b0;
   logic                ex_hold = 1'b0;
   logic [`W_FUNC-1:0]  mulalu_func = '0;
   logic                mulalu_sign = 1'b0;
   logic [`W_DATA-1:0]  source_a = '0;
   logic [`W_DATA-1:0]  source_b = '0;
   logic                busy, hi_write, lo_write;
   logic [`W_DATA-1:0]  hi_write_data, lo_write_data;

   int n_chk = 0;
   int n_err = 0;
   int n_wr;

   localparam logic [4:0] F_MUL = `FUNC_MUL;
   localparam logic [4:0] F_DIV = `FUNC_DIV;

   mulalu #(.MUL_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_hold(ex_hold),
      .mulalu_func(mulalu_func), .mulalu_sign(mulalu_sign),
      .source_a(source_a), .source_b(source_b),
      .busy(busy), .hi_write(hi_write), .hi_write_data(hi_write_data),
      .lo_write(lo_write), .lo_write_data(lo_write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents one op at T0, checks busy through T(nbusy-1) and the write at T(nbusy).
   task automatic run_op(input string tag, input logic [4:0] func, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int nbusy);
      @(posedge clk); #1;
      mulalu_func = func; mulalu_sign = sgn; source_a = a; source_b = b;
      for (int i = 0; i < nbusy; i++) begin
         @(negedge clk);
         chk({tag, " busy"}, {61'd0, busy, hi_write, lo_write}, 64'b100);
         @(posedge clk); #1;
         if (i == 0) mulalu_func = '0;
      end
      @(negedge clk);
      chk({tag, " wr"}, {61'd0, busy, hi_write, lo_write}, 64'b011);
      chk({tag, " hi"}, {32'd0, hi_write_data}, {32'd0, exp_hi});
      chk({tag, " lo"}, {32'd0, lo_write_data}, {32'd0, exp_lo});
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " post"}, {61'd0, busy, hi_write, lo_write}, 64'b000);
   endtask

   initial begin
      #12;
      chk("rst ctl", {61'd0, busy, hi_write, lo_write}, 64'b000);
      chk("rst data", {hi_write_data, lo_write_data}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("smul", F_MUL, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3);
      run_op("umul", F_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3);
      run_op("smul2", F_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3);
      run_op("sdiv", F_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("sdiv2", F_DIV, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
      run_op("udiv", F_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      run_op("udiv0", F_DIV, 1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
      run_op("sovf", F_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);

      // flush at T10 of a DIV
      @(posedge clk); #1;
      mulalu_func = F_DIV; mulalu_sign = 1'b0; source_a = 32'd1000; source_b = 32'd3;
      @(posedge clk); #1; mulalu_func = '0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush T10 busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1 flush = 1'b0;
      n_wr = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy || hi_write || lo_write) n_wr++;
      end
      chk("flush quiet", 64'(n_wr), 64'd0);
      run_op("mul after flush", F_MUL, 1'b0, 32'd12, 32'd11, 32'd0, 32'd132, 3);

      // ex_hold held 3 cycles in DONE with func still presented
      @(posedge clk); #1;
      mulalu_func = F_MUL; mulalu_sign = 1'b0; source_a = 32'd5; source_b = 32'd6;
      @(posedge clk); #1 mulalu_func = '0;
      @(posedge clk); #1;
      @(posedge clk); #1 ex_hold = 1'b1; mulalu_func = F_MUL;
      n_wr = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (hi_write && lo_write) n_wr++;
         chk("hold busy", {63'd0, busy}, 64'd0);
         chk("hold data", {hi_write_data, lo_write_data}, {32'd0, 32'd30});
         @(posedge clk); #1;
      end
      ex_hold = 1'b0; mulalu_func = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (hi_write || lo_write || busy) n_wr++;
         @(posedge clk); #1;
      end
      chk("hold one write", 64'(n_wr), 64'd1);
      @(negedge clk);
      chk("hold idle busy", {63'd0, busy}, 64'd0);

      // async reset at T5 of a DIV
      @(posedge clk); #1;
      mulalu_func = F_DIV; mulalu_sign = 1'b0; source_a = 32'd50; source_b = 32'd5;
      @(posedge clk); #1 mulalu_func = '0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst ctl", {61'd0, busy, hi_write, lo_write}, 64'b000);
      chk("arst data", {hi_write_data, lo_write_data}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      n_wr = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy || hi_write || lo_write) n_wr++;
      end
      chk("arst quiet", 64'(n_wr), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
